lab1_g29_vec_seq: RTL and testbench

Self-checking stimulus sequencer for the 4-input combinational stage (inputs G, T, U, E; output y).
- Sits directly upstream of that stage: drives all 16 input combinations in ascending order, holding each for a programmable number of cycles.
- Samples y back at the end of each hold window and builds the observed 16-entry truth table.
- Compares the observed table against an expected table and reports a mismatch count plus pass/done, so the stage can be exercised exhaustively in hardware as well as in simulation.

---
 rtl/lab1_g29_vec_seq.sv | 129 ++++++++++++
 tb/tb_lab1_g29_vec_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/lab1_g29_vec_seq.sv
// Exhaustive stimulus sequencer for a 4-input combinational stage. It walks vectors 0..15, samples y at
// the end of each hold window, and compares the observed truth table with a latched expected table.
module lab1_g29_vec_seq #(
    parameter int HOLD_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] exp_table,
    input  logic        y,
    output logic        g,
    output logic        t,
    output logic        u,
    output logic        e,
    output logic [3:0]  idx,
    output logic        busy,
    output logic        done,
    output logic [15:0] tt,
    output logic [4:0]  err_cnt,
    output logic        pass,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  hold_q, hold_d;
    logic [15:0] tt_q, tt_d;
    logic [15:0] exp_q, exp_d;
    logic [4:0]  err_q, err_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            hold_q  <= 8'd0;
            tt_q    <= 16'd0;
            exp_q   <= 16'd0;
            err_q   <= 5'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            tt_q    <= tt_d;
            exp_q   <= exp_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        tt_d    = tt_q;
        exp_d   = exp_q;
        err_d   = err_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE, DONE: begin
                // Restart from DONE behaves exactly like a fresh start from IDLE.
                if (start) begin
                    state_d = RUN;
                    idx_d   = 4'd0;
                    hold_d  = 8'd0;
                    tt_d    = 16'd0;
                    err_d   = 5'd0;
                    exp_d   = exp_table;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            RUN: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d      = 8'd0;
                    tt_d[idx_q] = y;
                    if (y != exp_q[idx_q]) begin
                        err_d = err_q + 5'd1;
                    end
                    // Last vector stays on the pins after the sweep ends.
                    if (idx_q == 4'd15) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == 5'd0);
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign g       = idx_q[3];
    assign t       = idx_q[2];
    assign u       = idx_q[1];
    assign e       = idx_q[0];
    assign idx     = idx_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign tt      = tt_q;
    assign err_cnt = err_q;
    assign pass    = pass_q;
    assign state   = state_q;

endmodule

// File: tb/tb_lab1_g29_vec_seq.sv
// Bench for lab1_g29_vec_seq: a driver issues sweeps against a modelled downstream stage, and a
// monitor checks the vector schedule and each sweep result taken from an expected queue.
module tb_lab1_g29_vec_seq;

    localparam int H = 4;
    localparam int W = 22; // {tt[15:0], err[4:0], pass}

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] exp_table = 16'd0;
    logic        y;
    logic        g, t, u, e, busy, done, pass;
    logic [3:0]  idx;
    logic [15:0] tt;
    logic [4:0]  err_cnt;
    logic [1:0]  state;

    logic [15:0] func = 16'hF000;     // truth table of the modelled stage
    logic [W-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int m_start = 0;
    bit m_active = 0;
    bit done_prev = 0;

    lab1_g29_vec_seq #(.HOLD_CYCLES(H)) dut (
        .clk(clk), .reset(reset), .start(start), .exp_table(exp_table), .y(y),
        .g(g), .t(t), .u(u), .e(e), .idx(idx), .busy(busy), .done(done),
        .tt(tt), .err_cnt(err_cnt), .pass(pass), .state(state)
    );

    assign y = func[{g, t, u, e}];

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // reference model: observed table equals the stage function; errors are differing bits
    function automatic logic [W-1:0] model(input logic [15:0] f, input logic [15:0] x);
        int n = 0;
        for (int i = 0; i < 16; i++) if (f[i] != x[i]) n++;
        return {f, 5'(n), (n == 0) ? 1'b1 : 1'b0};
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_idx"}, {28'd0, idx}, 32'd0);
        chk({tag, "_gtue"}, {28'd0, g, t, u, e}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_tt"}, {16'd0, tt}, 32'd0);
        chk({tag, "_err"}, {27'd0, err_cnt}, 32'd0);
        chk({tag, "_pass"}, {31'd0, pass}, 32'd0);
    endtask

    // driver tasks
    task automatic start_sweep(input logic [15:0] x);
        exp_table = x;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        m_start = cyc;
        m_active = 1;
        exp_q.push_back(model(func, x));
        chk("acc_busy", {31'd0, busy}, 32'd1);
        chk("acc_done", {31'd0, done}, 32'd0);
        chk("acc_pass", {31'd0, pass}, 32'd0);
        chk("acc_tt", {16'd0, tt}, 32'd0);
        chk("acc_err", {27'd0, err_cnt}, 32'd0);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 16 * H + 8 && m_active; i++) begin
            @(posedge clk);
            #1;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m_active = 0;
        exp_q.delete();
        @(posedge clk);
        #1;
        check_idle("rst");
        reset = 1'b0;
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        int k;
        logic [W-1:0] x;
        if (reset) begin
            done_prev = 0;
        end else begin
            k = cyc - m_start;
            if (m_active && k < 16 * H) begin
                chk("run_idx", {28'd0, idx}, 32'(k / H));
                chk("run_gtue", {28'd0, g, t, u, e}, 32'(k / H));
                chk("run_busy", {31'd0, busy}, 32'd1);
            end
            if (done && !done_prev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    x = exp_q.pop_front();
                    chk("done_cycle", 32'(k), 32'(16 * H));
                    chk("tt", {16'd0, tt}, {16'd0, x[21:6]});
                    chk("err_cnt", {27'd0, err_cnt}, {27'd0, x[5:1]});
                    chk("pass", {31'd0, pass}, {31'd0, x[0]});
                    chk("end_idx", {28'd0, idx}, 32'd15);
                    chk("end_gtue", {28'd0, g, t, u, e}, 32'd15);
                    chk("end_busy", {31'd0, busy}, 32'd0);
                end
                m_active = 0;
            end else if (m_active && k > 16 * H + 1) begin
                chk("done_timeout", 32'd0, 32'd1);
                void'(exp_q.pop_front());
                m_active = 0;
            end
            done_prev = done;
        end
    end

    initial begin
        logic [15:0] x;
        // reset held with start high
        reset = 1'b1;
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_idle("rst_start");
        reset = 1'b0;
        start_sweep(16'hF000);   // start still high on release: accepted next edge
        wait_done();
        start_sweep(16'hF003);
        wait_done();
        // restart from DONE with err_cnt=2
        start_sweep(16'hF000);
        wait_done();
        // start pulse at idx=5 must be ignored
        start_sweep(16'hF000);
        repeat (21) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();
        // reset at idx=7, then a full sweep
        start_sweep(16'hF000);
        repeat (29) @(posedge clk);
        #1;
        do_reset();
        start_sweep(16'hF003);
        wait_done();
        // randomized stage functions and expected tables
        for (int n = 0; n < 8; n++) begin
            func = 16'($urandom);
            x = ($urandom_range(0, 1) == 1) ? func : (func ^ 16'($urandom));
            start_sweep(x);
            repeat ($urandom_range(1, 40)) @(posedge clk);
            #1;
            exp_table = 16'($urandom);   // must not affect the running sweep
            wait_done();
        end
        if (exp_q.size() != 0) chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
